// File: rtl/cmn_sched_pkg.sv
// Shared scheduler helpers.
//   idx_w          : index width for a given entry count (minimum 1).
//   lsb_onehot     : one-hot of the lowest set bit of a vector (0 if none).
//   onehot_to_idx  : binary index of a one-hot vector (0 if none).
// Vectors are handled at MAX_DEPTH width. Callers zero-extend on the way in
// and truncate on the way out.
package cmn_sched_pkg;

  localparam int MAX_DEPTH = 64;

  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [MAX_DEPTH-1:0] lsb_onehot(input logic [MAX_DEPTH-1:0] v);
    return v & (~v + MAX_DEPTH'(1));
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_DEPTH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cmn_age_issue_sched_if.sv
// Bundle between dispatch/execution and the age-ordered issue scheduler.
//   master : drives flush, alloc_*, wake_mask and iss_rdy. Observes the rest.
//   slave  : the scheduler.
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Allocation uses alloc_vld/alloc_rdy, and issue uses iss_vld/iss_rdy.
// The scheduler's valid and ready outputs depend only on its registered state.
// Offering alloc_vld never waits on alloc_rdy.
// iss_idx/iss_data may change while iss_vld is high and iss_rdy is low.
// flush cancels both transfers in the cycle where it is high.
// dbg_vld/dbg_rdy expose the per-entry valid/ready state.
interface cmn_age_issue_sched_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
);
  localparam int IDX_W = cmn_sched_pkg::idx_w(DEPTH);

  logic              flush;
  logic              alloc_vld;
  logic              alloc_rdy;
  logic [DATA_W-1:0] alloc_data;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx;
  logic [DEPTH-1:0]  wake_mask;
  logic              iss_vld;
  logic              iss_rdy;
  logic [IDX_W-1:0]  iss_idx;
  logic [DATA_W-1:0] iss_data;
  logic [IDX_W:0]    count;
  logic [DEPTH-1:0]  dbg_vld;
  logic [DEPTH-1:0]  dbg_rdy;

  modport master (
    output flush, alloc_vld, alloc_data, alloc_ready, wake_mask, iss_rdy,
    input  alloc_rdy, alloc_idx, iss_vld, iss_idx, iss_data, count, dbg_vld, dbg_rdy
  );

  modport slave (
    input  flush, alloc_vld, alloc_data, alloc_ready, wake_mask, iss_rdy,
    output alloc_rdy, alloc_idx, iss_vld, iss_idx, iss_data, count, dbg_vld, dbg_rdy
  );
endinterface

// File: rtl/cmn_age_tracker.sv
// DEPTH x DEPTH age matrix. age[i][j]=1 means entry i is older than entry j.
//   clk, rst  : clock, synchronous active-high reset (matrix cleared)
//   alloc_oh  : one-hot entry being allocated this cycle (0 if none)
//   cand      : entries eligible for selection
//   grant_oh  : one-hot oldest eligible entry (0 if cand is 0)
module cmn_age_tracker #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] cand,
  output logic [DEPTH-1:0] grant_oh
);
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] blocked;

  // A new entry becomes younger than every other entry. Its row is cleared,
  // and its column is set everywhere except the diagonal.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) begin
        age_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != i) age_d[j][i] = 1'b1;
        end
      end
    end
  end

  // An entry is blocked when any older entry is also a candidate.
  always_comb begin
    blocked  = '0;
    grant_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        blocked[i] = blocked[i] | (cand[j] & age_q[j][i]);
      end
      grant_oh[i] = cand[i] & ~blocked[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
endmodule

// File: rtl/cmn_age_issue_sched.sv
// Oldest-first issue scheduler for a DEPTH-entry reservation buffer.
//   clk, rst : clock, synchronous active-high reset (equivalent to flush)
//   bus      : slave side of cmn_age_issue_sched_if
//              (allocation, wakeup, issue, count, debug state)
// Entries are allocated into the lowest free slot. They become ready at
// allocation or on wakeup, and the oldest ready entry is offered for issue.
// All outputs are derived from registered state only.
module cmn_age_issue_sched
  import cmn_sched_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  cmn_age_issue_sched_if.slave   bus
);
  localparam int IDX_W = idx_w(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  rdy_q, rdy_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [IDX_W:0]    count_q, count_d;

  logic [DEPTH-1:0]  free_vec, alloc_oh, cand, grant_oh, age_alloc_oh;
  logic              alloc_fire, iss_fire;
  logic [DATA_W-1:0] iss_data;

  assign free_vec   = ~vld_q;
  assign alloc_oh   = DEPTH'(lsb_onehot(MAX_DEPTH'(free_vec)));
  assign cand       = vld_q & rdy_q;
  assign alloc_fire = bus.alloc_vld & (|free_vec);
  assign iss_fire   = (|cand) & bus.iss_rdy;

  // Under flush, the age update is dropped because the slot never becomes valid.
  assign age_alloc_oh = (alloc_fire && !bus.flush) ? alloc_oh : '0;

  cmn_age_tracker #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .rst      (rst),
    .alloc_oh (age_alloc_oh),
    .cand     (cand),
    .grant_oh (grant_oh)
  );

  always_comb begin
    iss_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_oh[i]) iss_data = iss_data | data_q[i];
    end
  end

  // Wakeup is masked by the current valid state, so a wake bit aimed at the
  // slot being allocated this cycle is ignored.
  always_comb begin
    vld_d   = vld_q;
    rdy_d   = rdy_q | (bus.wake_mask & vld_q);
    data_d  = data_q;
    count_d = count_q;
    if (iss_fire) begin
      vld_d = vld_d & ~grant_oh;
      rdy_d = rdy_d & ~grant_oh;
    end
    if (alloc_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          vld_d[i]  = 1'b1;
          rdy_d[i]  = bus.alloc_ready;
          data_d[i] = bus.alloc_data;
        end
      end
    end
    case ({alloc_fire, iss_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (bus.flush) begin
      vld_d   = '0;
      rdy_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      rdy_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      count_q <= count_d;
    end
  end

  // The payload is only observed through a valid entry, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.alloc_rdy = |free_vec;
  assign bus.alloc_idx = IDX_W'(onehot_to_idx(MAX_DEPTH'(alloc_oh)));
  assign bus.iss_vld   = |cand;
  assign bus.iss_idx   = IDX_W'(onehot_to_idx(MAX_DEPTH'(grant_oh)));
  assign bus.iss_data  = iss_data;
  assign bus.count     = count_q;
  assign bus.dbg_vld   = vld_q;
  assign bus.dbg_rdy   = rdy_q;
endmodule

// File: doc/cmn_age_issue_sched.md
# cmn_age_issue_sched

Oldest-first issue scheduler for a DEPTH-entry reservation buffer. Entries are allocated into free slots, become ready by allocation-time flag or wakeup, and the oldest ready entry is presented for issue. Age order is held in an internal age matrix, and entries free on issue. Sits between dispatch and a single execution port in the OoO backend.

## Interface
- DEPTH, 8: number of entries, ≥2.
- DATA_W, 32: payload width per entry.
- IDX_W, $clog2(DEPTH): entry index width (derived).

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  invalidate all entries.
- alloc_vld  in  1  dispatch offers an entry.
- alloc_rdy  out  1  at least one free slot.
- alloc_data  in  DATA_W  payload to store.
- alloc_ready  in  1  entry is ready at allocation.
- alloc_idx  out  IDX_W  slot that the current offer will occupy.
- wake_mask  in  DEPTH  one bit per entry; sets that entry's ready bit.
- iss_vld  out  1  an oldest ready entry is selected.
- iss_rdy  in  1  execution port accepts.
- iss_idx  out  IDX_W  selected entry index.
- iss_data  out  DATA_W  selected entry payload.
- count  out  IDX_W+1  number of valid entries.

## Operation
- Per-entry state: vld, rdy, data. Age matrix `age[i][j]` = 1 means entry i is older than entry j. The diagonal is always 0.
- **Free-slot pick:** alloc_idx = lowest-index entry with vld=0, using registered state only. alloc_rdy = |~vld. alloc_idx = 0 when full.
- **Allocation:** alloc_vld && alloc_rdy. Next cycle, entry k=alloc_idx gets vld=1, rdy=alloc_ready, data=alloc_data.
  - Row k is cleared and column k is set for all j≠k, so k is younger than every other entry.
- **Wakeup:** rdy[i] is set for every i with wake_mask[i] && vld[i].
  - Wake bits for invalid entries are ignored, including a slot being allocated that same cycle.
- **Select:** cand = vld & rdy. Entry i wins if cand[i] && no j with cand[j] && age[j][i].
  - iss_vld = |cand. iss_idx and iss_data come from the winner.
  - When iss_vld=0: iss_idx=0 and iss_data=0.
- **Issue:** iss_vld && iss_rdy. The winner's vld and rdy clear next cycle.
  - Age bits of freed entries are don't-care; they are overwritten on reallocation.
- **Non-sticky offer:** while iss_rdy=0 the selection may change when an older entry wakes. The consumer must not assume iss_idx is stable across stalled cycles.
- **Flush:** all vld and rdy clear next cycle. Flush overrides allocation, wakeup and issue in the same cycle. count → 0.
- **count:** registered. It increments on allocation, decrements on issue, and is unchanged when both happen in one cycle.

## Timing
- **Reset values:** all vld/rdy/age = 0, count=0, alloc_rdy=1, alloc_idx=0, iss_vld=0, iss_idx=0, iss_data=0.
- **Reset mid-operation:** behaves as flush.
- All outputs are combinational from registered state; there is no comb path from any input to any output.
- **Latencies:**
  - Alloc → issuable: 1 cycle if alloc_ready=1.
  - Wake → issuable: 1 cycle.
  - Issue → slot reusable: 1 cycle.
- **Full with simultaneous issue:** alloc_rdy stays 0 that cycle (no bypass).
- **Empty:** iss_vld=0. Allocation proceeds normally.
- **Age ties:** impossible, because at most one allocation per cycle keeps the order total.

## Structure
- Shared package `cmn_sched_pkg`: IDX_W derivation helper and a lowest-set-bit one-hot/index function reused by other schedulers.
- Sub-module `cmn_age_tracker`: DEPTH×DEPTH age matrix with sync active-high reset.
  - Inputs: one-hot alloc, candidate vector.
  - Output: one-hot oldest-candidate grant.
- The top level holds the entry state, free-slot pick, payload mux and count.

## Test plan
- **Reset, then alloc A, B, C with alloc_ready=1, iss_rdy=1 →** issues A, B, C in order on cycles 2, 3, 4; count returns to 0.
- **Alloc A, B, C all not ready; wake C, then wake A+B together →** C issues first, then A, then B.
- **Fill DEPTH=8 entries →** alloc_rdy=0 and count=8.
  - Issue entry 3 with alloc_vld held → alloc_rdy=1 next cycle, alloc_idx=3.
  - The new entry becomes youngest: it issues last among ready entries.
- **Stall iss_rdy=0 with a ready young entry, then wake an older entry →** iss_idx switches to the older entry; no entry is lost.
- **Flush asserted with simultaneous alloc and issue handshakes →** next cycle all vld=0, count=0, iss_vld=0, and the allocated entry is absent.
- **Wake_mask on an invalid slot in the same cycle it is allocated with alloc_ready=0 →** the entry stays not ready (iss_vld=0).
